// File: rtl/cache_dre_ctrl.sv
// Sequencer owning the DRE store's refill/init write port: post-reset clear,
// then flush / invalidate / fill requests served one at a time.
module cache_dre_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  flush_done,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [1:0]            fill_ch,
    output logic                  fill_ack,
    input  logic                  inv_req,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    output logic                  inv_ack,
    output logic                  busy,
    output logic                  sel,
    output logic [ADDR_WIDTH-1:0] ri_writeAddress,
    output logic [1:0]            ri_writeChannel,
    output logic                  ri_writeEnable,
    output logic [7:0]            ri_writeData
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_INV   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_WIDTH:0] CNT_MAX = '1;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            ch_q, ch_d;
    logic [7:0]            data_q, data_d;
    logic                  flush_done_q, flush_done_d;
    logic                  fill_ack_q, fill_ack_d;
    logic                  inv_ack_q, inv_ack_d;

    // The half-word select bit never reaches the store; writes always cover the full word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = fill_addr[0] ^ inv_addr[0];

    // Outputs are registered from the next-state decode, so every output
    // reflects the state occupied during the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        ch_d         = ch_q;
        data_d       = 8'h00;
        flush_done_d = 1'b0;
        fill_ack_d   = 1'b0;
        inv_ack_d    = 1'b0;

        case (state_q)
            S_INIT, S_FLUSH: begin
                // we_q low only on the first edge after reset: emit write 0 without advancing.
                if (we_q && (cnt_q == CNT_MAX)) begin
                    state_d      = S_DONE;
                    sel_d        = 1'b0;
                    we_d         = 1'b0;
                    flush_done_d = 1'b1;
                end else begin
                    cnt_d  = we_q ? (cnt_q + CNT_ONE) : cnt_q;
                    sel_d  = 1'b1;
                    we_d   = 1'b1;
                    addr_d = {cnt_d[ADDR_WIDTH:2], 1'b0};
                    ch_d   = cnt_d[1:0];
                end
            end

            S_IDLE: begin
                sel_d = 1'b0;
                we_d  = 1'b0;
                if (flush_req) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                    sel_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    ch_d    = 2'd0;
                end else if (inv_req) begin
                    state_d = S_INV;
                    sel_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {inv_addr[ADDR_WIDTH-1:1], 1'b0};
                    ch_d    = 2'd0;
                end else if (fill_req) begin
                    state_d = S_FILL;
                    sel_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {fill_addr[ADDR_WIDTH-1:1], 1'b0};
                    ch_d    = fill_ch;
                    data_d  = 8'hFF;
                end
            end

            S_FILL: begin
                state_d    = S_DONE;
                sel_d      = 1'b0;
                we_d       = 1'b0;
                fill_ack_d = 1'b1;
            end

            S_INV: begin
                // Address stays latched in addr_q; only the channel walks 0..3.
                if (ch_q == 2'd3) begin
                    state_d   = S_DONE;
                    sel_d     = 1'b0;
                    we_d      = 1'b0;
                    inv_ack_d = 1'b1;
                end else begin
                    ch_d  = ch_q + 2'd1;
                    sel_d = 1'b1;
                    we_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                sel_d   = 1'b0;
                we_d    = 1'b0;
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                sel_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = '0;
                ch_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            sel_q        <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            ch_q         <= 2'd0;
            data_q       <= 8'h00;
            flush_done_q <= 1'b0;
            fill_ack_q   <= 1'b0;
            inv_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            ch_q         <= ch_d;
            data_q       <= data_d;
            flush_done_q <= flush_done_d;
            fill_ack_q   <= fill_ack_d;
            inv_ack_q    <= inv_ack_d;
        end
    end

    assign sel             = sel_q;
    assign busy            = sel_q;
    assign ri_writeEnable  = we_q;
    assign ri_writeAddress = addr_q;
    assign ri_writeChannel = ch_q;
    assign ri_writeData    = data_q;
    assign flush_done      = flush_done_q;
    assign fill_ack        = fill_ack_q;
    assign inv_ack         = inv_ack_q;

endmodule

// File: doc/cache_dre_ctrl.md
# cache_dre_ctrl

Sequencer for the cache's byte-readable-enable (DRE) store. It owns the store's refill/init write port and its `sel` mux. After reset it clears the whole store. It then serves three requests, one at a time, from the cache control FSM: flush (clear all), fill (mark a line fully readable in one channel) and invalidate (clear a line in all four channels). While it holds the store, it asserts `busy` so the read/write path stalls.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: DRE write-address width. Bit 0 selects the half-word; the store word is `addr[ADDR_WIDTH-1:1]`. Fixed 4 channels, 8 flag bits per channel per word.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush_req`  in  1  level request: clear every word, every channel
- `flush_done`  out  1  one-cycle completion pulse for flush and for the post-reset sweep
- `fill_req`  in  1  level request: set all 8 flags of one word/channel
- `fill_addr`  in  ADDR_WIDTH  fill address; bit 0 ignored
- `fill_ch`  in  2  fill channel
- `fill_ack`  out  1  one-cycle completion pulse
- `inv_req`  in  1  level request: clear one word in all 4 channels
- `inv_addr`  in  ADDR_WIDTH  invalidate address; bit 0 ignored
- `inv_ack`  out  1  one-cycle completion pulse
- `busy`  out  1  equals `sel`; the read/write path must not issue while high
- `sel`  out  1  DRE mux select; 1 = this block owns the write port
- `ri_writeAddress`  out  ADDR_WIDTH  DRE write address; bit 0 always 0
- `ri_writeChannel`  out  2  DRE write channel
- `ri_writeEnable`  out  1  DRE write strobe
- `ri_writeData`  out  8  DRE flag data; 8'hFF for fill, 8'h00 for flush and invalidate

## Operation
- States: `INIT`, `IDLE`, `FLUSH`, `FILL`, `INV`, `DONE`. `INIT` and `FLUSH` share one sweep datapath.
- All outputs are registered.
- Sweep counter `cnt`, ADDR_WIDTH+1 bits:
  - `cnt[1:0]` is the channel (minor).
  - `cnt[ADDR_WIDTH:2]` is the word index (major).
  - `ri_writeAddress = {cnt[ADDR_WIDTH:2],1'b0}`, `ri_writeChannel = cnt[1:0]`, `ri_writeData = 8'h00`, `ri_writeEnable = 1`.
  - `cnt` increments by 1 per cycle. The sweep ends after `cnt` = all-ones, i.e. 2^(ADDR_WIDTH+1) writes (512 at default).
- Reset: the state is `INIT` with `cnt = 0`. The sweep starts on the first clock edge after reset deasserts. At the end it goes to `DONE` and pulses `flush_done`.
- `IDLE`: `sel`, `busy`, `ri_writeEnable` = 0. Requests are sampled each cycle; the priority is flush > inv > fill. Address and channel are latched on the sampling edge.
- `FILL`: one write cycle. Address is `{fill_addr[ADDR_WIDTH-1:1],1'b0}`, channel is `fill_ch`, data is 8'hFF. Both halves of the word become readable. Then `DONE`.
- `INV`: four write cycles, channels 0,1,2,3 in order, fixed address, data 8'h00. Then `DONE`.
- `FLUSH`: the sweep described above, then `DONE`.
- `DONE`: one cycle. `sel` = 0. The matching ack/done is pulsed. Requests are not sampled. Then `IDLE`.
- A request arriving mid-operation is neither aborted nor pre-empted. It is sampled at the next `IDLE`.
- Simultaneous requests: the lower-priority ones stay pending and are served in later `IDLE` cycles in priority order.
- Requesters must drop their request in the cycle after its ack. Holding it longer re-triggers the operation; this is legal and idempotent.
- `rst` asserted in any state immediately forces `INIT`, clears `cnt` and zeroes all pulses. The sweep restarts from word 0, channel 0.

## Timing
Reset values:
- `sel` = `busy` = 1.
- `ri_writeEnable` = 0 during reset; it goes to 1 from the first post-reset edge.
- `ri_writeAddress` = 0, `ri_writeChannel` = 0, `ri_writeData` = 8'h00.
- All acks and `flush_done` = 0.

Fill latency, with the request sampled at edge N:
- Write is visible in cycle N+1.
- `fill_ack` is high in cycle N+2.
- `IDLE` resumes at N+3.

Invalidate latency: writes in cycles N+1..N+4, `inv_ack` at N+5.

Flush latency: writes in cycles N+1..N+512 (default), `flush_done` at N+513.

Gaps:
- The minimum gap between back-to-back operations is 2 cycles with `sel` = 0 (`DONE` + `IDLE`). This gives the read/write path a window.
- `sel` and `ri_writeEnable` are always high together while busy; there are no idle cycles inside an operation.

## Test plan
- Reset release: the sweep produces 512 writes. Address/channel sequence runs 0/0, 0/1, 0/2, 0/3, 2/0 … 254/3, all data 8'h00. Then `flush_done` pulses once and `sel` drops.
- `fill_req` with `fill_addr` = 8'h13, `fill_ch` = 2: one write of address 8'h12, channel 2, data 8'hFF. `fill_ack` two cycles after sampling.
- `inv_req` with `inv_addr` = 8'h40: four writes at 8'h40, channels 0..3, data 8'h00. `inv_ack` on the fifth cycle.
- `fill_req`, `inv_req` and `flush_req` raised in the same cycle: flush is served, then invalidate, then fill. Each ack arrives in order, separated by `DONE`/`IDLE` gaps.
- `rst` pulsed at sweep write 100: outputs return to reset values. The sweep restarts at 0/0 and completes all 512 writes; no `flush_done` pulse for the aborted sweep.
- `fill_req` held 3 cycles past `fill_ack`: a second identical fill is performed. No request is sampled during `DONE`.
